// File: rtl/pixel_pkg.sv
// Shared types for the pixel stream framer and its FIFO.
// The FIFO entry carries the pixel word plus its frame-position tag.
package pixel_pkg;

    typedef enum logic {
        S_HDR = 1'b0,
        S_PIX = 1'b1
    } state_t;

    localparam int unsigned HDR_BYTES = 4;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } pix_tag_t;

    // The data field width follows CHANNELS, so the full entry struct
    // {data, sof, eol, eof} is completed inside the parameterised top.
    function automatic int unsigned pix_width(input int unsigned channels);
        return 8 * channels;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO with synchronous flush.
// A write while full is accepted only when a pop happens at the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             wr_ok;
    logic             rd_ok;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    assign rd_ok = rd_en && !empty && !flush;
    assign wr_ok = wr_en && !flush && (!full || rd_ok);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(wr_ok) - CW'(rd_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign count   = cnt;

endmodule

// File: rtl/pixel_stream_framer.sv
// Parses a 4-byte height/width header, assembles CHANNELS-byte pixels and
// queues them with sof/eol/eof tags behind a valid/ready FIFO.
module pixel_stream_framer
    import pixel_pkg::*;
#(
    parameter int unsigned CHANNELS   = 3,
    parameter int unsigned DIM_W      = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [7:0]              byte_in,
    input  logic                    byte_valid,
    input  logic                    abort,
    output logic [8*CHANNELS-1:0]   pix_data,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic                    pix_sof,
    output logic                    pix_eol,
    output logic                    pix_eof,
    output logic [DIM_W-1:0]        height,
    output logic [DIM_W-1:0]        width,
    output logic                    hdr_valid,
    output logic                    dim_err,
    output logic                    overflow,
    output logic                    busy
);

    localparam int unsigned PIX_W = pix_width(CHANNELS);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [PIX_W-1:0] data;
        pix_tag_t         tag;
    } fifo_entry_t;

    state_t             state_q, state_d;
    logic [1:0]         hdr_cnt;
    logic [23:0]        hdr_sr;
    logic [31:0]        hdr_word;
    logic [DIM_W-1:0]   h_new, w_new;
    logic [DIM_W-1:0]   x, y;
    logic [1:0]         ch;
    logic [PIX_W-1:0]   hold, px_word;
    logic               hdr_ok, hdr_bad, px_last;
    logic               is_sof, is_eol, is_eof;
    fifo_entry_t        wr_entry, head;
    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    assign hdr_word = {hdr_sr, byte_in};
    assign h_new    = DIM_W'(hdr_word[31:16]);
    assign w_new    = DIM_W'(hdr_word[15:0]);
    // Holding register is a byte shift register; truncation keeps byte 0 in the MSBs.
    assign px_word  = PIX_W'({hold, byte_in});
    assign is_sof   = (x == '0) && (y == '0);
    assign is_eol   = (x == width - DIM_W'(1));
    assign is_eof   = is_eol && (y == height - DIM_W'(1));

    always_comb begin
        state_d = state_q;
        hdr_ok  = 1'b0;
        hdr_bad = 1'b0;
        px_last = 1'b0;
        if (abort) begin
            state_d = S_HDR;
        end else if (byte_valid) begin
            unique case (state_q)
                S_HDR: begin
                    if (hdr_cnt == 2'(HDR_BYTES - 1)) begin
                        if (h_new != '0 && w_new != '0) begin
                            hdr_ok  = 1'b1;
                            state_d = S_PIX;
                        end else begin
                            hdr_bad = 1'b1;
                        end
                    end
                end
                S_PIX: begin
                    if (ch == 2'(CHANNELS - 1)) begin
                        px_last = 1'b1;
                        if (is_eof) state_d = S_HDR;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_HDR;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hdr_cnt   <= '0;
            hdr_sr    <= '0;
            x         <= '0;
            y         <= '0;
            ch        <= '0;
            hold      <= '0;
            height    <= '0;
            width     <= '0;
            hdr_valid <= 1'b0;
            dim_err   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            dim_err <= hdr_bad;
            if (hdr_ok)
                overflow <= 1'b0;
            else if (px_last && fifo_full && !pix_ready)
                overflow <= 1'b1;

            if (abort) begin
                hdr_cnt   <= '0;
                x         <= '0;
                y         <= '0;
                ch        <= '0;
                hdr_valid <= 1'b0;
            end else if (byte_valid) begin
                if (state_q == S_HDR) begin
                    hdr_sr  <= hdr_word[23:0];
                    hdr_cnt <= hdr_cnt + 2'd1;
                    if (hdr_ok) begin
                        height    <= h_new;
                        width     <= w_new;
                        hdr_valid <= 1'b1;
                        x         <= '0;
                        y         <= '0;
                        ch        <= '0;
                    end
                end else if (px_last) begin
                    ch <= '0;
                    if (is_eol) begin
                        x <= '0;
                        y <= y + DIM_W'(1);
                    end else begin
                        x <= x + DIM_W'(1);
                    end
                    if (is_eof) hdr_valid <= 1'b0;
                end else begin
                    hold <= px_word;
                    ch   <= ch + 2'd1;
                end
            end
        end
    end

    always_comb begin
        wr_entry.data    = px_word;
        wr_entry.tag.sof = is_sof;
        wr_entry.tag.eol = is_eol;
        wr_entry.tag.eof = is_eof;
    end

    sync_fifo #(
        .WIDTH($bits(fifo_entry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .flush   (abort),
        .wr_en   (px_last),
        .wr_data (wr_entry),
        .rd_en   (pix_ready),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Head outputs are forced to zero while empty so stale entries never leak.
    assign pix_valid = !fifo_empty;
    assign pix_data  = pix_valid ? head.data    : '0;
    assign pix_sof   = pix_valid ? head.tag.sof : 1'b0;
    assign pix_eol   = pix_valid ? head.tag.eol : 1'b0;
    assign pix_eof   = pix_valid ? head.tag.eof : 1'b0;
    assign busy      = (state_q != S_HDR) || (fifo_count != '0);

endmodule

// File: tb/tb_pixel_stream_framer.sv
// Bench for pixel_stream_framer: an RGB/depth-4 instance and a mono/8-bit-dim
// instance, each compared every cycle against a frame-level reference model.
module tb_pixel_stream_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic [7:0] bin  [2];
    logic       bval [2];
    logic       abrt [2];
    logic       rdy  [2];

    logic [23:0] a_data;
    logic [15:0] a_h, a_w;
    logic        a_v, a_sof, a_eol, a_eof, a_hv, a_derr, a_ovf, a_busy;
    logic [7:0]  b_data;
    logic [7:0]  b_h, b_w;
    logic        b_v, b_sof, b_eol, b_eof, b_hv, b_derr, b_ovf, b_busy;

    pixel_stream_framer #(.CHANNELS(3), .DIM_W(16), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rstn(rstn), .byte_in(bin[0]), .byte_valid(bval[0]), .abort(abrt[0]),
        .pix_data(a_data), .pix_valid(a_v), .pix_ready(rdy[0]), .pix_sof(a_sof),
        .pix_eol(a_eol), .pix_eof(a_eof), .height(a_h), .width(a_w), .hdr_valid(a_hv),
        .dim_err(a_derr), .overflow(a_ovf), .busy(a_busy)
    );

    pixel_stream_framer #(.CHANNELS(1), .DIM_W(8), .FIFO_DEPTH(8)) dut_b (
        .clk(clk), .rstn(rstn), .byte_in(bin[1]), .byte_valid(bval[1]), .abort(abrt[1]),
        .pix_data(b_data), .pix_valid(b_v), .pix_ready(rdy[1]), .pix_sof(b_sof),
        .pix_eol(b_eol), .pix_eof(b_eof), .height(b_h), .width(b_w), .hdr_valid(b_hv),
        .dim_err(b_derr), .overflow(b_ovf), .busy(b_busy)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        sof;
        logic        eol;
        logic        eof;
    } exp_t;

    typedef struct {
        logic [31:0] data, h, w;
        logic        v, sof, eol, eof, hv, derr, ovf, busy;
    } obs_t;

    int vec_cnt = 0;
    int miscmp_cnt = 0;

    // Reference model state: pixels are indexed linearly, x/y derived from it.
    exp_t        mq     [2][16];
    int unsigned m_qn   [2];
    int unsigned m_hcnt [2];
    int unsigned m_bcnt [2];
    int unsigned m_pixn [2];
    int unsigned m_h    [2];
    int unsigned m_w    [2];
    logic [31:0] m_acc  [2];
    logic [7:0]  m_hdr  [2][4];
    bit          m_inpix[2], m_hv[2], m_ovf[2], m_derr[2];

    logic [31:0] plog_d [2][64];
    logic [2:0]  plog_f [2][64];
    int          plog_n [2];
    int          derr_n [2];

    function automatic int unsigned m_ch(input int k);    return (k == 0) ? 3 : 1; endfunction
    function automatic int unsigned m_depth(input int k); return (k == 0) ? 4 : 8; endfunction
    function automatic int unsigned m_dimw(input int k);  return (k == 0) ? 16 : 8; endfunction

    function automatic string tg(input int k, input string s);
        string p;
        p = (k == 0) ? "a." : "b.";
        return {p, s};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic obs_t get_obs(input int k);
        obs_t o;
        if (k == 0) begin
            o.data = 32'(a_data); o.h = 32'(a_h); o.w = 32'(a_w);
            o.v = a_v; o.sof = a_sof; o.eol = a_eol; o.eof = a_eof;
            o.hv = a_hv; o.derr = a_derr; o.ovf = a_ovf; o.busy = a_busy;
        end else begin
            o.data = 32'(b_data); o.h = 32'(b_h); o.w = 32'(b_w);
            o.v = b_v; o.sof = b_sof; o.eol = b_eol; o.eof = b_eof;
            o.hv = b_hv; o.derr = b_derr; o.ovf = b_ovf; o.busy = b_busy;
        end
        return o;
    endfunction

    task automatic model_reset(input int k);
        m_qn[k] = 0; m_hcnt[k] = 0; m_bcnt[k] = 0; m_pixn[k] = 0;
        m_h[k] = 0; m_w[k] = 0; m_acc[k] = '0;
        m_inpix[k] = 0; m_hv[k] = 0; m_ovf[k] = 0; m_derr[k] = 0;
    endtask

    task automatic model_step(input int k, input logic bv, input logic [7:0] b,
                              input logic ab, input logic rd);
        bit pop, was_full;
        int unsigned h, w, x;
        exp_t e;
        pop = (m_qn[k] != 0) && rd;
        was_full = (m_qn[k] == m_depth(k));
        m_derr[k] = 0;
        if (ab) begin
            m_qn[k] = 0; m_inpix[k] = 0; m_hcnt[k] = 0; m_bcnt[k] = 0;
            m_acc[k] = '0; m_hv[k] = 0;
            return;
        end
        if (pop) begin
            for (int i = 1; i < 16; i++) mq[k][i-1] = mq[k][i];
            m_qn[k]--;
        end
        if (!bv) return;
        if (!m_inpix[k]) begin
            m_hdr[k][m_hcnt[k]] = b;
            m_hcnt[k]++;
            if (m_hcnt[k] == 4) begin
                m_hcnt[k] = 0;
                h = 32'({m_hdr[k][0], m_hdr[k][1]}) % (32'd1 << m_dimw(k));
                w = 32'({m_hdr[k][2], m_hdr[k][3]}) % (32'd1 << m_dimw(k));
                if (h != 0 && w != 0) begin
                    m_h[k] = h; m_w[k] = w; m_hv[k] = 1; m_ovf[k] = 0;
                    m_inpix[k] = 1; m_pixn[k] = 0; m_bcnt[k] = 0; m_acc[k] = '0;
                end else begin
                    m_derr[k] = 1;
                end
            end
        end else begin
            m_acc[k] = (m_acc[k] << 8) | 32'(b);
            m_bcnt[k]++;
            if (m_bcnt[k] == m_ch(k)) begin
                x = m_pixn[k] % m_w[k];
                e.data = m_acc[k];
                e.sof  = (m_pixn[k] == 0);
                e.eol  = (x == m_w[k] - 1);
                e.eof  = (m_pixn[k] == m_h[k] * m_w[k] - 1);
                if (was_full && !pop) m_ovf[k] = 1;
                else begin mq[k][m_qn[k]] = e; m_qn[k]++; end
                m_bcnt[k] = 0; m_acc[k] = '0; m_pixn[k]++;
                if (e.eof) begin m_hv[k] = 0; m_inpix[k] = 0; end
            end
        end
    endtask

    task automatic check_all(input int k);
        obs_t o;
        logic v;
        exp_t hd;
        o = get_obs(k);
        v = (m_qn[k] != 0);
        hd = mq[k][0];
        check(tg(k, "pix_valid"), 32'(o.v),   32'(v));
        check(tg(k, "pix_data"),  o.data,     v ? hd.data : 32'd0);
        check(tg(k, "pix_sof"),   32'(o.sof), v ? 32'(hd.sof) : 32'd0);
        check(tg(k, "pix_eol"),   32'(o.eol), v ? 32'(hd.eol) : 32'd0);
        check(tg(k, "pix_eof"),   32'(o.eof), v ? 32'(hd.eof) : 32'd0);
        check(tg(k, "hdr_valid"), 32'(o.hv),  32'(m_hv[k]));
        check(tg(k, "height"),    o.h,        m_h[k]);
        check(tg(k, "width"),     o.w,        m_w[k]);
        check(tg(k, "dim_err"),   32'(o.derr), 32'(m_derr[k]));
        check(tg(k, "overflow"),  32'(o.ovf), 32'(m_ovf[k]));
        check(tg(k, "busy"),      32'(o.busy), 32'(m_inpix[k] || v));
    endtask

    task automatic cycle();
        obs_t o;
        for (int k = 0; k < 2; k++) begin
            o = get_obs(k);
            if (rstn && o.v && rdy[k] && !abrt[k] && plog_n[k] < 64) begin
                plog_d[k][plog_n[k]] = o.data;
                plog_f[k][plog_n[k]] = {o.sof, o.eol, o.eof};
                plog_n[k]++;
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rstn) model_reset(k);
            else       model_step(k, bval[k], bin[k], abrt[k], rdy[k]);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_all(k);
            o = get_obs(k);
            if (o.derr) derr_n[k]++;
        end
    endtask

    task automatic put(input int k, input logic [7:0] b);
        bin[k] = b; bval[k] = 1'b1;
        cycle();
        bval[k] = 1'b0;
    endtask

    task automatic put4(input int k, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
        put(k, b0); put(k, b1); put(k, b2); put(k, b3);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    function automatic logic [7:0] pick_byte(input int k);
        if (m_inpix[k]) return 8'($urandom);
        if (m_hcnt[k] == 0 || m_hcnt[k] == 2)
            return (k == 1 && $urandom_range(0, 7) == 0) ? 8'h01 : 8'h00;
        return 8'($urandom_range(0, 4));
    endfunction

    initial begin
        bit any_eof;
        rstn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bin[k] = '0; bval[k] = 1'b0; abrt[k] = 1'b0; rdy[k] = 1'b0;
            plog_n[k] = 0; derr_n[k] = 0;
            model_reset(k);
        end
        idle(2);
        rstn = 1'b1;
        idle(1);

        // 2x2 RGB frame
        rdy[0] = 1'b1; plog_n[0] = 0;
        put4(0, 8'h00, 8'h02, 8'h00, 8'h02);
        put(0, 8'h11); put(0, 8'h22); put(0, 8'h33);
        put(0, 8'h44); put(0, 8'h55); put(0, 8'h66);
        put(0, 8'h77); put(0, 8'h88); put(0, 8'h99);
        put(0, 8'hAA); put(0, 8'hBB); put(0, 8'hCC);
        idle(4);
        check("rgb.pops", 32'(plog_n[0]), 32'd4);
        check("rgb.p0", plog_d[0][0], 32'h112233);
        check("rgb.p1", plog_d[0][1], 32'h445566);
        check("rgb.p2", plog_d[0][2], 32'h778899);
        check("rgb.p3", plog_d[0][3], 32'hAABBCC);
        check("rgb.f0", 32'(plog_f[0][0]), 32'b100);
        check("rgb.f1", 32'(plog_f[0][1]), 32'b010);
        check("rgb.f2", 32'(plog_f[0][2]), 32'b000);
        check("rgb.f3", 32'(plog_f[0][3]), 32'b011);
        check("rgb.hdr_valid", 32'(a_hv), 32'd0);
        check("rgb.busy", 32'(a_busy), 32'd0);

        // Stall: 1x6 frame into a 4-deep FIFO with no ready
        rdy[0] = 1'b0;
        put4(0, 8'h00, 8'h01, 8'h00, 8'h06);
        for (int i = 0; i < 18; i++) put(0, 8'(8'h30 + i));
        idle(2);
        check("stall.overflow", 32'(a_ovf), 32'd1);
        check("stall.valid", 32'(a_v), 32'd1);
        plog_n[0] = 0; rdy[0] = 1'b1;
        idle(8);
        check("stall.pops", 32'(plog_n[0]), 32'd4);
        any_eof = 0;
        for (int i = 0; i < plog_n[0]; i++) if (plog_f[0][i][0]) any_eof = 1;
        check("stall.eof_seen", 32'(any_eof), 32'd0);
        put4(0, 8'h00, 8'h01, 8'h00, 8'h01);
        check("stall.ovf_cleared", 32'(a_ovf), 32'd0);
        put(0, 8'h01); put(0, 8'h02); put(0, 8'h03);
        idle(2);

        // Zero dimension, then a 1x1 frame
        derr_n[0] = 0;
        put4(0, 8'h00, 8'h00, 8'h00, 8'h05);
        idle(2);
        check("zero.pulses", 32'(derr_n[0]), 32'd1);
        check("zero.hdr_valid", 32'(a_hv), 32'd0);
        plog_n[0] = 0;
        put4(0, 8'h00, 8'h01, 8'h00, 8'h01);
        put(0, 8'h5A); put(0, 8'hA5); put(0, 8'h3C);
        idle(3);
        check("zero.pops", 32'(plog_n[0]), 32'd1);
        check("zero.data", plog_d[0][0], 32'h5AA53C);
        check("zero.flags", 32'(plog_f[0][0]), 32'b111);

        // Abort after two of four pixels
        rdy[0] = 1'b0;
        put4(0, 8'h00, 8'h02, 8'h00, 8'h02);
        for (int i = 0; i < 6; i++) put(0, 8'(8'hE0 + i));
        idle(1);
        abrt[0] = 1'b1; cycle(); abrt[0] = 1'b0;
        check("abort.valid", 32'(a_v), 32'd0);
        check("abort.busy", 32'(a_busy), 32'd0);
        rdy[0] = 1'b1; plog_n[0] = 0;
        put4(0, 8'h00, 8'h02, 8'h00, 8'h02);
        put(0, 8'hD1); put(0, 8'hD2); put(0, 8'hD3);
        idle(3);
        check("abort.pops", 32'(plog_n[0]), 32'd1);
        check("abort.data", plog_d[0][0], 32'hD1D2D3);
        check("abort.sof", 32'(plog_f[0][0][2]), 32'd1);
        for (int i = 0; i < 9; i++) put(0, 8'(i));
        idle(3);

        // Mono 3x1 frame, back-to-back bytes; header high byte truncated to 8 bits
        rdy[1] = 1'b1; plog_n[1] = 0;
        put4(1, 8'h01, 8'h03, 8'h00, 8'h01);
        put(1, 8'h0A); put(1, 8'h0B); put(1, 8'h0C);
        idle(3);
        check("mono.height", 32'(b_h), 32'd3);
        check("mono.pops", 32'(plog_n[1]), 32'd3);
        check("mono.p0", plog_d[1][0], 32'h0A);
        check("mono.p1", plog_d[1][1], 32'h0B);
        check("mono.p2", plog_d[1][2], 32'h0C);
        check("mono.f0", 32'(plog_f[1][0]), 32'b110);
        check("mono.f1", 32'(plog_f[1][1]), 32'b010);
        check("mono.f2", 32'(plog_f[1][2]), 32'b011);

        // Asynchronous reset between bytes of a pixel
        rdy[0] = 1'b0;
        put4(0, 8'h00, 8'h02, 8'h00, 8'h02);
        put(0, 8'h41); put(0, 8'h42); put(0, 8'h43); put(0, 8'h44);
        #2 rstn = 1'b0;
        #1;
        model_reset(0); model_reset(1);
        check_all(0); check_all(1);
        check("rst.busy", 32'(a_busy), 32'd0);
        idle(2);
        rstn = 1'b1;
        rdy[0] = 1'b1;
        put(0, 8'h11); put(0, 8'h22); put(0, 8'h33);
        idle(2);
        check("rst.no_pixel", 32'(a_v), 32'd0);
        abrt[0] = 1'b1; abrt[1] = 1'b1; cycle(); abrt[0] = 1'b0; abrt[1] = 1'b0;

        // Randomized traffic on both instances
        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < 2; k++) begin
                bval[k] = ($urandom_range(0, 9) < 6);
                abrt[k] = ($urandom_range(0, 149) == 0);
                rdy[k]  = ($urandom_range(0, 9) < 6);
                bin[k]  = pick_byte(k);
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule

// File: doc/pixel_stream_framer.md
Name: pixel_stream_framer

Overview:
- Parametrised successor of the byte-stream image parser between the UART receiver and the rgb2gray/sobel stages.
- Collects a 4-byte dimension header, then assembles CHANNELS bytes per pixel.
- Tags each pixel with start-of-frame, end-of-line and end-of-frame flags.
- Buffers pixels in a small FIFO behind a valid/ready handshake, so a stalling downstream stage does not corrupt the non-stallable UART stream.

Parameters:
- CHANNELS, 3, bytes per pixel (legal 1..4); byte 0 lands in the MSBs of pix_data.
- DIM_W, 16, width of the height and width fields.
- FIFO_DEPTH, 8, pixel FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  system clock (UART sample strobe arrives as byte_valid, not as a clock).
- rstn  in  1  asynchronous active-low reset.
- byte_in  in  8  received byte.
- byte_valid  in  1  one-cycle strobe; byte_in is valid this cycle; there is no back-pressure.
- abort  in  1  synchronous frame abort.
- pix_data  out  8*CHANNELS  assembled pixel.
- pix_valid  out  1  FIFO head valid.
- pix_ready  in  1  downstream accepts head when pix_valid & pix_ready.
- pix_sof  out  1  head is pixel (0,0).
- pix_eol  out  1  head is the last pixel of its line.
- pix_eof  out  1  head is the last pixel of the frame.
- height  out  DIM_W  latched height.
- width  out  DIM_W  latched width.
- hdr_valid  out  1  dimensions latched and nonzero.
- dim_err  out  1  one-cycle pulse: header with zero height or width.
- overflow  out  1  sticky; pixel dropped because FIFO full.
- busy  out  1  state ≠ S_HDR or FIFO not empty.

Behaviour:
- Reset (rstn low, asynchronous): state S_HDR, all counters 0, FIFO empty, every output 0.
- S_HDR: consumes 4 bytes on byte_valid, in order height[15:8], height[7:0], width[15:8], width[7:0]. For DIM_W≠16, the low DIM_W bits of the 16-bit field are kept.
  - On the 4th byte with both fields nonzero: height/width registered, hdr_valid=1, overflow cleared, x=y=ch=0, go S_PIX.
  - On the 4th byte with either field zero: dim_err pulses one cycle later, hdr_valid=0, stay in S_HDR.
- S_PIX:
  - Each byte goes into slot ch of the holding register; ch++.
  - On byte ch==CHANNELS-1: the pixel {holding, byte_in} is written to the FIFO at that same edge with flags sof=(x==0&&y==0), eol=(x==width-1), eof=eol&&(y==height-1). pix_valid can rise the next cycle (1-cycle latency, first-word fall-through). ch=0.
  - x wraps to 0 at width-1 with y++.
  - After the eof pixel: hdr_valid=0, go S_HDR. Height/width keep their values until the next header.
- FIFO:
  - Pop on pix_valid&pix_ready.
  - Write while full with a simultaneous pop is accepted; count is unchanged.
  - Write while full without a pop drops the pixel and sets overflow. Counters still advance, so frame geometry stays aligned.
  - Outputs are driven from the head entry; they are stable while pix_valid&!pix_ready.
- abort (priority over byte_valid, below reset):
  - Same edge: state S_HDR, counters 0, FIFO flushed, hdr_valid=0.
  - overflow is kept.
- byte_valid with CHANNELS=1: every byte is a pixel. No bubble is required between bytes.

Decomposition:
- Shared package pixel_pkg:
  - state enum {S_HDR, S_PIX};
  - HDR_BYTES=4;
  - localparam PIX_W=8*CHANNELS;
  - FIFO entry struct {data, sof, eol, eof}.
- One sub-module, sync_fifo (WIDTH, DEPTH): first-word fall-through, full/empty/count, asynchronous active-low reset, synchronous flush. It is reusable for the sobel line stage.

Test Plan:
- 2×2 RGB frame:
  - Stimulus: header 00 02 00 02, then bytes 11 22 33, 44 55 66, 77 88 99, AA BB CC, with pix_ready=1.
  - Required: pix_data 112233/445566/778899/AABBCC; flags sof on pixel 0, eol on 1 and 3, eof on 3.
  - Required: hdr_valid drops after eof, busy=0 after the final pop.
- Stall:
  - Stimulus: FIFO_DEPTH=4, 1×6 frame, pix_ready=0 throughout.
  - Required: 4 pixels held, pixels 5 and 6 dropped, overflow=1.
  - Then pix_ready=1 → exactly 4 pops; pix_eof never seen.
  - Next header clears overflow.
- Zero dimension:
  - Stimulus: header 00 00 00 05.
  - Required: dim_err single pulse, hdr_valid=0.
  - Then a following valid 1×1 header plus 3 bytes yields one pixel with sof=eol=eof=1.
- Abort:
  - Stimulus: abort after 2 of 4 pixels of a 2×2 frame, with pix_ready=0.
  - Required: FIFO empty, pix_valid=0 next cycle.
  - Then a new header is accepted and its first pixel carries sof.
- CHANNELS=1, 3×1 frame:
  - Stimulus: bytes 0A 0B 0C on back-to-back cycles.
  - Required: pix_data 0A,0B,0C; eol on each; eof on 0C.
- Reset mid-pixel:
  - Stimulus: rstn low asynchronously between bytes.
  - Required: all outputs 0 immediately.
  - After release, a full header is required before any pixel appears.
